// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus for the RV32I decode stage.
// The master side feeds instructions and consumes decoded entries; the
// slave side is the decode stage itself.
interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_imm;
  logic [3:0]       out_alu_op;
  logic [5:0]       out_cu_op;
  logic             out_reg_write;
  logic             out_mem_write;
  logic             out_mem_read;
  logic             out_alu_src;
  logic             out_illegal;

  logic [CNT_W-1:0] stat_decoded;
  logic [CNT_W-1:0] stat_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_cu_op, out_reg_write, out_mem_write, out_mem_read,
           out_alu_src, out_illegal, stat_decoded, stat_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_cu_op, out_reg_write, out_mem_write, out_mem_read,
           out_alu_src, out_illegal, stat_decoded, stat_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming instruction into
// a control bundle, held in a two-entry buffer (output register + skid
// register) so the upstream ready depends only on local state. Illegal
// encodings are still handed downstream as a zeroed ERROR entry.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR, ALU_AND,
    ALU_SLL, ALU_SRA, ALU_SLTU, ALU_SLT, ALU_SRL
  } alu_op_e;

  typedef enum logic [5:0] {
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
    CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA,
    CU_OR, CU_AND, CU_ERROR
  } cu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [5:0]      cu_op;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            alu_src;
    logic            illegal;
  } dec_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_sh;
  logic            w_r_funct7_ok;
  logic            w_sr_funct7_ok;
  logic            w_illegal;
  dec_t            w_dec;

  dec_t            r_out;
  dec_t            r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic [CNT_W-1:0] r_stat_decoded;
  logic [CNT_W-1:0] r_stat_illegal;

  logic            w_accept;
  logic            w_out_fire;

  assign w_opcode = bus.in_instr[6:0];
  assign w_rd     = bus.in_instr[11:7];
  assign w_funct3 = bus.in_instr[14:12];
  assign w_rs1    = bus.in_instr[19:15];
  assign w_rs2    = bus.in_instr[24:20];
  assign w_funct7 = bus.in_instr[31:25];

  // Signed casts sign-extend each immediate to the full datapath width.
  assign w_imm_i  = XLEN'($signed(bus.in_instr[31:20]));
  assign w_imm_s  = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
  assign w_imm_b  = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                   bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
  assign w_imm_u  = XLEN'($signed({bus.in_instr[31:12], 12'h000}));
  assign w_imm_j  = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                   bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
  assign w_imm_sh = XLEN'(bus.in_instr[24:20]);

  // The alternate funct7 only exists for SUB and SRA/SRAI.
  assign w_r_funct7_ok  = (w_funct7 == F7_BASE) ||
                          ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
  assign w_sr_funct7_ok = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);

  // Decode the incoming instruction into a control bundle.
  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    w_dec.pc  = bus.in_pc;
    case (w_opcode)
      OPC_LUI: begin
        w_dec.cu_op     = CU_LUI;
        w_dec.rd        = w_rd;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.cu_op     = CU_AUIPC;
        w_dec.rd        = w_rd;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_dec.cu_op     = CU_JAL;
        w_dec.rd        = w_rd;
        w_dec.imm       = w_imm_j;
        w_dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        w_dec.cu_op     = CU_JALR;
        w_dec.rs1       = w_rs1;
        w_dec.rd        = w_rd;
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_illegal       = (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_dec.rs1    = w_rs1;
        w_dec.rs2    = w_rs2;
        w_dec.imm    = w_imm_b;
        w_dec.alu_op = ALU_SUB;
        case (w_funct3)
          3'b000:  w_dec.cu_op = CU_BEQ;
          3'b001:  w_dec.cu_op = CU_BNE;
          3'b100:  w_dec.cu_op = CU_BLT;
          3'b101:  w_dec.cu_op = CU_BGE;
          3'b110:  w_dec.cu_op = CU_BLTU;
          3'b111:  w_dec.cu_op = CU_BGEU;
          default: w_illegal   = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec.rs1       = w_rs1;
        w_dec.rd        = w_rd;
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_read  = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.cu_op = CU_LB;
          3'b001:  w_dec.cu_op = CU_LH;
          3'b010:  w_dec.cu_op = CU_LW;
          3'b100:  w_dec.cu_op = CU_LBU;
          3'b101:  w_dec.cu_op = CU_LHU;
          default: w_illegal   = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.imm       = w_imm_s;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.cu_op = CU_SB;
          3'b001:  w_dec.cu_op = CU_SH;
          3'b010:  w_dec.cu_op = CU_SW;
          default: w_illegal   = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_dec.rs1       = w_rs1;
        w_dec.rd        = w_rd;
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        case (w_funct3)
          3'b000: begin w_dec.cu_op = CU_ADDI;  w_dec.alu_op = ALU_ADD;  end
          3'b010: begin w_dec.cu_op = CU_SLTI;  w_dec.alu_op = ALU_SLT;  end
          3'b011: begin w_dec.cu_op = CU_SLTIU; w_dec.alu_op = ALU_SLTU; end
          3'b100: begin w_dec.cu_op = CU_XORI;  w_dec.alu_op = ALU_XOR;  end
          3'b110: begin w_dec.cu_op = CU_ORI;   w_dec.alu_op = ALU_OR;   end
          3'b111: begin w_dec.cu_op = CU_ANDI;  w_dec.alu_op = ALU_AND;  end
          3'b001: begin
            w_dec.cu_op  = CU_SLLI;
            w_dec.alu_op = ALU_SLL;
            w_dec.imm    = w_imm_sh;
            w_illegal    = (w_funct7 != F7_BASE);
          end
          default: begin
            w_dec.imm = w_imm_sh;
            w_illegal = !w_sr_funct7_ok;
            if (bus.in_instr[30]) begin
              w_dec.cu_op  = CU_SRAI;
              w_dec.alu_op = ALU_SRA;
            end else begin
              w_dec.cu_op  = CU_SRLI;
              w_dec.alu_op = ALU_SRL;
            end
          end
        endcase
      end
      OPC_OP: begin
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.rd        = w_rd;
        w_dec.reg_write = 1'b1;
        w_illegal       = !w_r_funct7_ok;
        case (w_funct3)
          3'b000: begin
            if (bus.in_instr[30]) begin
              w_dec.cu_op  = CU_SUB;
              w_dec.alu_op = ALU_SUB;
            end else begin
              w_dec.cu_op  = CU_ADD;
              w_dec.alu_op = ALU_ADD;
            end
          end
          3'b001: begin w_dec.cu_op = CU_SLL;  w_dec.alu_op = ALU_SLL;  end
          3'b010: begin w_dec.cu_op = CU_SLT;  w_dec.alu_op = ALU_SLT;  end
          3'b011: begin w_dec.cu_op = CU_SLTU; w_dec.alu_op = ALU_SLTU; end
          3'b100: begin w_dec.cu_op = CU_XOR;  w_dec.alu_op = ALU_XOR;  end
          3'b110: begin w_dec.cu_op = CU_OR;   w_dec.alu_op = ALU_OR;   end
          3'b111: begin w_dec.cu_op = CU_AND;  w_dec.alu_op = ALU_AND;  end
          default: begin
            if (bus.in_instr[30]) begin
              w_dec.cu_op  = CU_SRA;
              w_dec.alu_op = ALU_SRA;
            end else begin
              w_dec.cu_op  = CU_SRL;
              w_dec.alu_op = ALU_SRL;
            end
          end
        endcase
      end
      default: w_illegal = 1'b1;
    endcase

    // Illegal entries travel downstream with everything but pc zeroed.
    if (w_illegal) begin
      w_dec         = '0;
      w_dec.pc      = bus.in_pc;
      w_dec.cu_op   = CU_ERROR;
      w_dec.illegal = 1'b1;
    end else if (w_dec.rd == 5'd0) begin
      w_dec.reg_write = 1'b0;
    end
  end

  // The skid register only fills while the output is stalled, so "skid
  // empty" is the same as "buffer has room".
  assign w_accept   = bus.in_valid & ~r_skid_valid;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // Two-entry buffer: the skid entry refills the output ahead of new input.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || bus.out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  // Saturating handshake counters; flush leaves them alone.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_stat_decoded <= '0;
      r_stat_illegal <= '0;
    end else if (w_out_fire) begin
      if (r_stat_decoded != '1) begin
        r_stat_decoded <= r_stat_decoded + CNT_W'(1);
      end
      if (r_out.illegal && (r_stat_illegal != '1)) begin
        r_stat_illegal <= r_stat_illegal + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready      = ~r_skid_valid;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out.pc;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_alu_op    = r_out.alu_op;
  assign bus.out_cu_op     = r_out.cu_op;
  assign bus.out_reg_write = r_out.reg_write;
  assign bus.out_mem_write = r_out.mem_write;
  assign bus.out_mem_read  = r_out.mem_read;
  assign bus.out_alu_src   = r_out.alu_src;
  assign bus.out_illegal   = r_out.illegal;
  assign bus.stat_decoded  = r_stat_decoded;
  assign bus.stat_illegal  = r_stat_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by random traffic,
// all checked against a queue-based reference model with table-driven decode.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic nRst  = 1'b1;
  logic flush = 1'b0;

  decode_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) ifc();

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .nRst  (nRst),
    .flush (flush),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [5:0]  cu_op;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        alu_src;
    logic        illegal;
  } exp_t;

  exp_t mq[$];
  int   m_dec = 0;
  int   m_ill = 0;
  int   checks = 0;
  int   errors = 0;

  int br_tbl [8]  = '{4, 5, -1, -1, 6, 7, 8, 9};
  int ld_tbl [8]  = '{10, 11, 12, -1, 13, 14, -1, -1};
  int st_tbl [8]  = '{15, 16, 17, -1, -1, -1, -1, -1};
  int i_tbl  [8]  = '{18, 24, 19, 20, 21, 25, 22, 23};
  int r_tbl  [8]  = '{27, 29, 30, 31, 32, 33, 35, 36};
  int alu_tbl[38] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 8, 7, 3, 2, 4, 5, 9, 6, 0, 1, 5, 8, 7, 3, 9, 6, 2, 4, 0};
  logic [6:0] opc_tbl[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t obs_bundle();
    exp_t o;
    o.pc = ifc.out_pc;               o.rs1 = ifc.out_rs1;
    o.rs2 = ifc.out_rs2;             o.rd = ifc.out_rd;
    o.imm = ifc.out_imm;             o.alu_op = ifc.out_alu_op;
    o.cu_op = ifc.out_cu_op;         o.reg_write = ifc.out_reg_write;
    o.mem_write = ifc.out_mem_write; o.mem_read = ifc.out_mem_read;
    o.alu_src = ifc.out_alu_src;     o.illegal = ifc.out_illegal;
    return o;
  endfunction

  function automatic exp_t ref_dec(logic [31:0] ins, logic [31:0] pc);
    exp_t e = '0;
    int cu = -1;
    bit u1 = 0, u2 = 0, wr = 0, src = 0, ld = 0, st = 0;
    logic [31:0] imm = '0;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    case (ins[6:0])
      7'h37: begin cu = 0; wr = 1; imm = {ins[31:12], 12'h000}; end
      7'h17: begin cu = 1; wr = 1; imm = {ins[31:12], 12'h000}; end
      7'h6F: begin
        cu = 2; wr = 1;
        imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        if (f3 == 3'd0) cu = 3;
        u1 = 1; wr = 1; src = 1; imm = int'($signed(ins[31:20]));
      end
      7'h63: begin
        cu = br_tbl[f3]; u1 = 1; u2 = 1;
        imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h03: begin cu = ld_tbl[f3]; u1 = 1; wr = 1; src = 1; ld = 1; imm = int'($signed(ins[31:20])); end
      7'h23: begin
        cu = st_tbl[f3]; u1 = 1; u2 = 1; src = 1; st = 1;
        imm = int'($signed({ins[31:25], ins[11:7]}));
      end
      7'h13: begin
        cu = i_tbl[f3]; u1 = 1; wr = 1; src = 1; imm = int'($signed(ins[31:20]));
        if (f3 == 3'd1) begin
          imm = 32'(ins[24:20]);
          if (f7 != 7'h00) cu = -1;
        end else if (f3 == 3'd5) begin
          imm = 32'(ins[24:20]);
          if (f7 != 7'h00 && f7 != 7'h20) cu = -1;
          else if (ins[30]) cu = 26;
        end
      end
      7'h33: begin
        cu = r_tbl[f3]; u1 = 1; u2 = 1; wr = 1;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) cu = cu + 1;
        else if (f7 != 7'h00) cu = -1;
      end
      default: cu = -1;
    endcase
    e.pc = pc;
    if (cu < 0) begin
      e.cu_op = 6'd37;
      e.illegal = 1'b1;
    end else begin
      e.cu_op = 6'(cu);
      e.alu_op = 4'(alu_tbl[cu]);
      e.rs1 = u1 ? ins[19:15] : 5'd0;
      e.rs2 = u2 ? ins[24:20] : 5'd0;
      e.rd = wr ? ins[11:7] : 5'd0;
      e.imm = imm;
      e.reg_write = wr && (ins[11:7] != 5'd0);
      e.alu_src = src;
      e.mem_read = ld;
      e.mem_write = st;
    end
    return e;
  endfunction

  // Compare current outputs with the model, then advance both by one edge.
  task automatic cycle();
    bit fire, acc;
    exp_t e;
    chk("in_ready", ifc.in_ready, mq.size() < 2);
    chk("out_valid", ifc.out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_bundle", obs_bundle(), mq[0]);
    chk("stat_decoded", ifc.stat_decoded, m_dec);
    chk("stat_illegal", ifc.stat_illegal, m_ill);
    fire = (mq.size() > 0) && ifc.out_ready;
    acc  = ifc.in_valid && (mq.size() < 2);
    e    = ref_dec(ifc.in_instr, ifc.in_pc);
    @(posedge clk);
    if (fire) begin
      if (m_dec < SAT) m_dec++;
      if (mq[0].illegal && m_ill < SAT) m_ill++;
    end
    if (flush) mq.delete();
    else begin
      if (fire) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    #2;
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_in_ready", ifc.in_ready, 1'b1);
    chk("rst_stat_decoded", ifc.stat_decoded, 0);
    chk("rst_stat_illegal", ifc.stat_illegal, 0);
    chk("rst_out_pc", ifc.out_pc, 0);
    chk("rst_out_imm", ifc.out_imm, 0);
    chk("rst_out_cu_op", ifc.out_cu_op, 0);
    chk("rst_out_rd", ifc.out_rd, 0);
    mq.delete();
    m_dec = 0;
    m_ill = 0;
    #1 nRst = 1'b1;
  endtask

  task automatic put(logic [31:0] ins, logic [31:0] pc);
    ifc.in_valid = 1'b1;
    ifc.in_instr = ins;
    ifc.in_pc    = pc;
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int sel = $urandom_range(0, 10);
    if (sel < 9) begin
      r[6:0] = opc_tbl[sel];
      if ($urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return r;
  endfunction

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_instr  = '0;
    ifc.in_pc     = '0;
    ifc.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // addi x1,x2,-1
    ifc.out_ready = 1'b1;
    put(32'hFFF10093, 32'h100);
    cycle();
    idle();
    chk("addi_valid", ifc.out_valid, 1'b1);
    chk("addi_rs1", ifc.out_rs1, 5'd2);
    chk("addi_rd", ifc.out_rd, 5'd1);
    chk("addi_imm", ifc.out_imm, 32'hFFFFFFFF);
    chk("addi_alu", ifc.out_alu_op, 4'd0);
    chk("addi_cu", ifc.out_cu_op, 6'd18);
    chk("addi_rw", ifc.out_reg_write, 1'b1);
    chk("addi_src", ifc.out_alu_src, 1'b1);
    cycle();

    // sub then add, back-to-back
    put(32'h402081B3, 32'h104);
    cycle();
    put(32'h002081B3, 32'h108);
    chk("sub_alu", ifc.out_alu_op, 4'd1);
    chk("sub_cu", ifc.out_cu_op, 6'd28);
    chk("sub_rs1", ifc.out_rs1, 5'd1);
    chk("sub_rs2", ifc.out_rs2, 5'd2);
    chk("sub_rd", ifc.out_rd, 5'd3);
    chk("sub_rw", ifc.out_reg_write, 1'b1);
    cycle();
    idle();
    chk("add_alu", ifc.out_alu_op, 4'd0);
    chk("add_cu", ifc.out_cu_op, 6'd27);
    cycle();

    // beq x0,x0,-4
    put(32'hFE000EE3, 32'h10C);
    cycle();
    idle();
    chk("beq_cu", ifc.out_cu_op, 6'd4);
    chk("beq_alu", ifc.out_alu_op, 4'd1);
    chk("beq_imm", ifc.out_imm, 32'hFFFFFFFC);
    chk("beq_rw", ifc.out_reg_write, 1'b0);
    cycle();

    // ordering under backpressure
    do_reset();
    ifc.out_ready = 1'b0;
    put(32'hFFF10093, 32'h200);
    cycle();
    put(32'h402081B3, 32'h204);
    cycle();
    put(32'hFE000EE3, 32'h208);
    chk("ord_full_ready", ifc.in_ready, 1'b0);
    cycle();
    chk("ord_hold_ready", ifc.in_ready, 1'b0);
    chk("ord_hold_pc", ifc.out_pc, 32'h200);
    ifc.out_ready = 1'b1;
    cycle();
    chk("ord_second_pc", ifc.out_pc, 32'h204);
    cycle();
    idle();
    chk("ord_third_pc", ifc.out_pc, 32'h208);
    cycle();
    chk("ord_stat_decoded", ifc.stat_decoded, 3);
    chk("ord_drained", ifc.out_valid, 1'b0);

    // illegal encodings
    do_reset();
    put(32'h00000000, 32'h300);
    cycle();
    put(32'h02208033, 32'h304);
    chk("ill0_flag", ifc.out_illegal, 1'b1);
    chk("ill0_cu", ifc.out_cu_op, 6'd37);
    chk("ill0_rw", ifc.out_reg_write, 1'b0);
    cycle();
    idle();
    chk("ill1_flag", ifc.out_illegal, 1'b1);
    chk("ill1_cu", ifc.out_cu_op, 6'd37);
    chk("ill1_rw", ifc.out_reg_write, 1'b0);
    chk("ill1_rs1", ifc.out_rs1, 5'd0);
    chk("ill1_imm", ifc.out_imm, 32'd0);
    cycle();
    chk("ill_stat_illegal", ifc.stat_illegal, 2);

    // flush with two entries buffered and input offered
    ifc.out_ready = 1'b0;
    put(32'hFFF10093, 32'h400);
    cycle();
    put(32'h00500113, 32'h404);
    cycle();
    put(32'h00600193, 32'h408);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    chk("flush_valid", ifc.out_valid, 1'b0);
    chk("flush_ready", ifc.in_ready, 1'b1);
    chk("flush_stat_decoded", ifc.stat_decoded, 2);
    chk("flush_stat_illegal", ifc.stat_illegal, 2);
    cycle();

    // flush drops a same-cycle transfer while ready is high
    put(32'h00700213, 32'h40C);
    cycle();
    put(32'h00800293, 32'h410);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    chk("flush_drop_valid", ifc.out_valid, 1'b0);
    cycle();

    // reset pulse with entries buffered and input held
    put(32'hFFF10093, 32'h500);
    cycle();
    put(32'h00500113, 32'h504);
    cycle();
    put(32'h00600193, 32'h508);
    do_reset();
    cycle();
    idle();
    chk("rst_first_accept_valid", ifc.out_valid, 1'b1);
    chk("rst_first_accept_pc", ifc.out_pc, 32'h508);
    ifc.out_ready = 1'b1;
    cycle();

    // counter saturation
    do_reset();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put(32'hFFF10093, 32'h600 + 32'(4 * i));
      cycle();
    end
    idle();
    cycle();
    chk("sat_stat_decoded", ifc.stat_decoded, 4'hF);
    chk("sat_stat_illegal", ifc.stat_illegal, 4'h0);

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0) put(rand_instr(), $urandom);
      else idle();
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (flush) ifc.out_ready = 1'b0;
      cycle();
    end
    flush = 1'b0;
    idle();
    ifc.out_ready = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
